// File: rtl/job_launcher.sv
// -----------------------------------------------------------------------------
// job_launcher
//
// Initiator side of a start/busy/done worker handshake. A job request carries
// a repeat count; the launcher pulses start_o once per repetition, waiting for
// the worker's done_i pulse in between. A per-launch watchdog aborts the job
// when done_i does not arrive within TIMEOUT_CYCLES wait cycles. Exactly one
// response (completed count + error flag) is returned per accepted request.
//
// Optional feature (compile-time macro JOB_LAUNCHER_BUSY_CHK_EN):
//   when defined, the worker must raise busy_i in the first wait cycle after a
//   start (unless it already signals done_i); otherwise the job is aborted.
//   When undefined, busy_i is ignored.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready_o, req_count_i       job request (repeat count)
//   start_o            one-cycle start pulse to the worker
//   busy_i, done_i     worker status (busy only used with the optional check)
//   rsp_valid_o/ready_i, rsp_done_cnt_o, rsp_err_o   job response
//
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module job_launcher #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [CNT_W-1:0] req_count_i,
    output logic             start_o,
    input  logic             busy_i,
    input  logic             done_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [CNT_W-1:0] rsp_done_cnt_o,
    output logic             rsp_err_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             first_wait_q, first_wait_d;

    // Output flops, loaded from the next state so they line up with state_q.
    logic req_ready_q, start_q, rsp_valid_q;

`ifndef JOB_LAUNCHER_BUSY_CHK_EN
    logic unused_busy;
    assign unused_busy = busy_i;
`endif

    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        done_cnt_d   = done_cnt_q;
        timer_d      = timer_q;
        err_d        = err_q;
        first_wait_d = first_wait_q;

        case (state_q)
            S_IDLE: begin
                // req_ready_o is always high here, so valid alone completes
                // the handshake.
                if (req_valid_i) begin
                    req_cnt_d  = req_count_i;
                    done_cnt_d = '0;
                    err_d      = 1'b0;
                    timer_d    = '0;
                    state_d    = (req_count_i == '0) ? S_RESP : S_START;
                end
            end

            S_START: begin
                timer_d      = '0;
                first_wait_d = 1'b1;
                state_d      = S_WAIT;
            end

            S_WAIT: begin
                first_wait_d = 1'b0;
                // done_i has priority over both abort conditions.
                if (done_i) begin
                    done_cnt_d = done_cnt_q + CNT_ONE;
                    timer_d    = '0;
                    state_d    = (done_cnt_d == req_cnt_q) ? S_RESP : S_START;
                end
`ifdef JOB_LAUNCHER_BUSY_CHK_EN
                else if (first_wait_q && !busy_i) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
                else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d      = S_IDLE;
                req_cnt_d    = '0;
                done_cnt_d   = '0;
                timer_d      = '0;
                err_d        = 1'b0;
                first_wait_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            req_cnt_q    <= '0;
            done_cnt_q   <= '0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            first_wait_q <= 1'b0;
            req_ready_q  <= 1'b1;
            start_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            done_cnt_q   <= done_cnt_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            first_wait_q <= first_wait_d;
            req_ready_q  <= (state_d == S_IDLE);
            start_q      <= (state_d == S_START);
            rsp_valid_q  <= (state_d == S_RESP);
        end
    end

    assign req_ready_o    = req_ready_q;
    assign start_o        = start_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_done_cnt_o = done_cnt_q;
    assign rsp_err_o      = err_q;

endmodule

// File: doc/job_launcher.md
Name: job_launcher

Overview:
- Initiator for the start/busy/done worker handshake. Takes a job request carrying a repeat count on a valid/ready port and drives one `start_o` pulse per repetition to a worker.
- After each pulse it waits for the worker's one-cycle `done_i`. A per-launch watchdog aborts the job if `done_i` does not arrive in time.
- Returns one response per request: repetitions completed plus an error flag.
- Sits between a command source (sequencer/CSR) and any worker that exposes `start`/`busy`/`done`.

Parameters:
- CNT_W, 8, width of the repeat count and the completed count.
- TIMEOUT_CYCLES, 64, maximum number of S_WAIT cycles per launch. Must be ≥1 and ≥ the worker's busy length + 1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  job request valid
- req_ready_o  output  1  launcher can accept a request
- req_count_i  input  CNT_W  number of launches requested
- start_o  output  1  one-cycle start pulse to worker
- busy_i  input  1  worker busy; only used with the optional feature
- done_i  input  1  worker one-cycle completion pulse
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response accepted
- rsp_done_cnt_o  output  CNT_W  launches completed
- rsp_err_o  output  1  job aborted (timeout or busy check)

Behaviour:
- States: S_IDLE, S_START, S_WAIT, S_RESP. Illegal encodings go to S_IDLE with all counters cleared.
- Reset: state S_IDLE; request count, completed count, timer and error flag all 0.
  - Outputs during and after reset: `req_ready_o`=1, `start_o`=0, `rsp_valid_o`=0, `rsp_done_cnt_o`=0, `rsp_err_o`=0.
- All outputs are decoded from state or registers only. No combinational input-to-output paths.
- S_IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i` & `req_ready_o`: latch `req_count_i`, clear completed count and error flag.
  - Count ≠ 0 → S_START. Count = 0 → S_RESP directly, with `rsp_done_cnt_o`=0 and `rsp_err_o`=0.
- S_START:
  - `start_o`=1 for exactly this one cycle. Clear timer. → S_WAIT.
- S_WAIT:
  - On `done_i`: increment completed count and clear timer. If the new count equals the latched count → S_RESP, else → S_START.
  - Otherwise, if timer == TIMEOUT_CYCLES−1: set error, → S_RESP with completed count unchanged.
  - Otherwise timer increments by 1.
- Simultaneous `done_i` and timeout: done wins; no error.
- S_RESP:
  - `rsp_valid_o`=1; `rsp_done_cnt_o` and `rsp_err_o` held stable until `rsp_ready_i`.
  - On `rsp_ready_i` → S_IDLE.
- `req_ready_o`=0 in every state except S_IDLE; a new request is never accepted in the same cycle a response completes.
- `done_i` outside S_WAIT is ignored.
- Latency, request accepted at cycle T:
  - `start_o` at T+1.
  - Against a worker with busy length N: `done_i` at T+N+2, next `start_o` at T+N+3.
  - Per-launch period N+2 cycles.
- Widths: timer is $clog2(TIMEOUT_CYCLES+1) bits. Completed count cannot exceed the latched count, so it never wraps.
- Reset asserted mid-job: immediate return to the reset values above. No response is produced for the aborted job.

Optional Feature:
- Macro: JOB_LAUNCHER_BUSY_CHK_EN.
- Defined:
  - In the first S_WAIT cycle after a start, `busy_i` must be 1 unless `done_i` is also 1.
  - If `busy_i`=0 and `done_i`=0 that cycle: set error, → S_RESP next cycle with completed count unchanged.
- Undefined: `busy_i` is ignored entirely.

Test Plan:
- Reset, then idle, against a worker with busy length 5 and TIMEOUT_CYCLES=64 → `req_ready_o`=1, `start_o`=0, `rsp_valid_o`=0 throughout.
- `req_count_i`=3, same worker, `rsp_ready_i`=1 → `start_o` pulses at T+1, T+8, T+15 → `rsp_valid_o` at T+22 with `rsp_done_cnt_o`=3, `rsp_err_o`=0 → `req_ready_o`=1 at T+23.
- `req_count_i`=0 → `rsp_valid_o` at T+1, `rsp_done_cnt_o`=0, `rsp_err_o`=0, no `start_o` pulse.
- TIMEOUT_CYCLES=4, worker busy length 5, `req_count_i`=2 → single `start_o` → `rsp_err_o`=1, `rsp_done_cnt_o`=0; the late `done_i` at T+7 is ignored.
- `rsp_ready_i` held 0 for 10 cycles with `req_valid_i`=1 → response fields stable, `req_ready_o`=0, no request accepted until the cycle after the `rsp_ready_i` handshake.
- With JOB_LAUNCHER_BUSY_CHK_EN, stub worker never raises `busy_i` or `done_i` → `rsp_err_o`=1 one cycle after the first S_WAIT cycle. Without the macro, the same stimulus times out after TIMEOUT_CYCLES.
